// File: rtl/fb_scan_arbiter.sv
`default_nettype none
// ============================================================================
// fb_scan_arbiter: shares the framebuffer between prefetching VGA scanout and
// the pixel writer; FB_ARB_VBLANK_WRITE_EN blocks writes for the whole of FETCH.
// Revision: 1.0
// ============================================================================
module fb_scan_arbiter #(
  parameter int H_DISPLAY    = 640,
  parameter int V_DISPLAY    = 480,
  parameter int PIX_PER_WORD = 8,
  parameter int ADDR_W       = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      sc_frame_start,
  input  logic                      sc_pix_en,
  output logic [2:0]                sc_rgb,
  output logic                      sc_underrun,
  input  logic                      wr_valid,
  output logic                      wr_ready,
  input  logic [9:0]                wr_x,
  input  logic [8:0]                wr_y,
  input  logic [2:0]                wr_rgb,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic                      mem_re,
  input  logic [3*PIX_PER_WORD-1:0] mem_rdata,
  output logic                      mem_we,
  output logic [3*PIX_PER_WORD-1:0] mem_wdata,
  output logic [3*PIX_PER_WORD-1:0] mem_wmask
);

  localparam int WORD_W = 3 * PIX_PER_WORD;
  localparam int IDX_W  = $clog2(PIX_PER_WORD);
  localparam int SH_W   = $clog2(WORD_W);
  localparam logic [ADDR_W-1:0] NUM_WORDS = ADDR_W'(H_DISPLAY * V_DISPLAY / PIX_PER_WORD);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(PIX_PER_WORD - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t              state, state_nx;
  logic [ADDR_W-1:0]   rd_ptr;
  logic                rd_pend;
  logic [WORD_W-1:0]   buf_q [2];
  logic                buf_head;
  logic [1:0]          buf_cnt;
  logic [IDX_W-1:0]    pix_idx;
  logic                buf_empty;
  logic                push;
  logic                pop;
  logic [WORD_W-1:0]   head_shift;
  logic [SH_W-1:0]     pix_sh;
  logic [SH_W-1:0]     lane_sh;
  logic [ADDR_W-1:0]   wr_addr;
  logic                wr_in_range;

  always_comb begin
    state_nx = state;
    if (sc_frame_start) begin
      state_nx = S_FETCH;
    end else if (state == S_FETCH && rd_ptr == NUM_WORDS) begin
      state_nx = S_DONE;
    end
  end

  // A read is never issued in a frame-start cycle, so nothing is left in
  // flight past the flush; data returning in that cycle is simply not pushed.
  assign mem_re = (state == S_FETCH) && !sc_frame_start && (rd_ptr < NUM_WORDS) &&
                  (({1'b0, buf_cnt} + {2'b00, rd_pend}) < 3'd2);

  assign buf_empty  = (buf_cnt == 2'd0);
  assign push       = rd_pend && !sc_frame_start;
  assign pop        = sc_pix_en && !sc_frame_start && !buf_empty && (pix_idx == LAST_IDX);
  assign pix_sh     = SH_W'(pix_idx) * SH_W'(3);
  assign head_shift = buf_q[buf_head] >> pix_sh;

  // y*80 + x/8 without a multiplier
  assign wr_addr     = ADDR_W'({wr_y, 6'b0}) + ADDR_W'({wr_y, 4'b0}) + ADDR_W'(wr_x[9:3]);
  assign wr_in_range = (wr_x < 10'(H_DISPLAY)) && (wr_y < 9'(V_DISPLAY));
  assign lane_sh     = SH_W'(wr_x[2:0]) * SH_W'(3);

`ifdef FB_ARB_VBLANK_WRITE_EN
  assign wr_ready = !mem_re && (state != S_FETCH);
`else
  assign wr_ready = !mem_re;
`endif

  assign mem_we    = wr_valid && wr_ready && wr_in_range;
  assign mem_addr  = mem_re ? rd_ptr : wr_addr;
  assign mem_wdata = WORD_W'(wr_rgb) << lane_sh;
  assign mem_wmask = WORD_W'(3'b111) << lane_sh;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      rd_ptr      <= '0;
      rd_pend     <= 1'b0;
      buf_head    <= 1'b0;
      buf_cnt     <= 2'd0;
      pix_idx     <= '0;
      sc_rgb      <= 3'd0;
      sc_underrun <= 1'b0;
    end else begin
      state   <= state_nx;
      rd_pend <= mem_re;
      if (sc_frame_start) begin
        rd_ptr      <= '0;
        buf_head    <= 1'b0;
        buf_cnt     <= 2'd0;
        pix_idx     <= '0;
        sc_rgb      <= 3'd0;
        sc_underrun <= 1'b0;
      end else begin
        if (mem_re) begin
          rd_ptr <= rd_ptr + ADDR_W'(1);
        end
        if (pop) begin
          buf_head <= ~buf_head;
        end
        buf_cnt <= buf_cnt + {1'b0, push} - {1'b0, pop};
        sc_rgb  <= 3'd0;
        if (sc_pix_en) begin
          if (buf_empty) begin
            sc_underrun <= 1'b1;
          end else begin
            sc_rgb  <= head_shift[2:0];
            pix_idx <= (pix_idx == LAST_IDX) ? '0 : pix_idx + IDX_W'(1);
          end
        end
      end
    end
  end

  // Tail slot is head+count; count is at most 1 whenever data returns.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_q[buf_head ^ buf_cnt[0]] <= mem_rdata;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fb_scan_arbiter.sv
`default_nettype none
// ============================================================================
// tb_fb_scan_arbiter: pixel-level model with per-cycle compare plus literal pins.
// Revision: 1.0
// ============================================================================
module tb_fb_scan_arbiter;

  localparam int WORDS = 38400;
  localparam int NPIX  = 307200;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sc_frame_start = 1'b0;
  logic        sc_pix_en = 1'b0;
  logic [2:0]  sc_rgb;
  logic        sc_underrun;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [9:0]  wr_x = '0;
  logic [8:0]  wr_y = '0;
  logic [2:0]  wr_rgb = '0;
  logic [15:0] mem_addr;
  logic        mem_re;
  logic [23:0] mem_rdata = '0;
  logic        mem_we;
  logic [23:0] mem_wdata;
  logic [23:0] mem_wmask;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fb_scan_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .sc_frame_start(sc_frame_start), .sc_pix_en(sc_pix_en),
    .sc_rgb(sc_rgb), .sc_underrun(sc_underrun),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_x(wr_x), .wr_y(wr_y), .wr_rgb(wr_rgb),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_rdata(mem_rdata),
    .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // framebuffer RAM, one-cycle read latency
  logic [23:0] ram [WORDS];
  always @(posedge clk) begin
    if (mem_re && mem_addr < 16'(WORDS)) mem_rdata <= ram[mem_addr];
    if (mem_we && mem_addr < 16'(WORDS))
      ram[mem_addr] <= (ram[mem_addr] & ~mem_wmask) | (mem_wdata & mem_wmask);
  end

  // pixel-level model of what the screen should show
  logic [2:0] fbpix [NPIX];
  bit         m_in_frame = 1'b0;
  bit         m_done = 1'b0;
  bit         m_ur = 1'b0;
  bit [2:0]   m_rgb = 3'd0;
  int         m_reads = 0;
  int         m_pix = 0;
  int         m_cyc = 0;
  int         rd_cyc [256];

  always @(negedge clk) begin : p_cmp
    bit e_re, e_ready, e_we, avail;
    int lim, wa, ln, j;
    lim = m_pix / 8 + 2;
    if (lim > WORDS) lim = WORDS;
    e_re = m_in_frame && !sc_frame_start && (m_reads < lim);
`ifdef FB_ARB_VBLANK_WRITE_EN
    e_ready = !e_re && !(m_in_frame && !m_done);
`else
    e_ready = !e_re;
`endif
    e_we = wr_valid && e_ready && (int'(wr_x) < 640) && (int'(wr_y) < 480);
    wa = int'(wr_y) * 80 + int'(wr_x) / 8;
    ln = int'(wr_x) % 8;

    chk("mem_re", 32'(mem_re), 32'(e_re));
    chk("wr_ready", 32'(wr_ready), 32'(e_ready));
    chk("mem_we", 32'(mem_we), 32'(e_we));
    chk("re_we_excl", 32'(mem_re && mem_we), 32'd0);
    if (e_re && mem_re) chk("rd_addr", 32'(mem_addr), 32'(m_reads));
    if (e_we && mem_we) begin
      chk("wr_addr", 32'(mem_addr), 32'(wa));
      chk("wr_data", 32'(mem_wdata), 32'(wr_rgb) << (3 * ln));
      chk("wr_mask", 32'(mem_wmask), 32'd7 << (3 * ln));
    end
    chk("sc_rgb", 32'(sc_rgb), 32'(m_rgb));
    chk("sc_underrun", 32'(sc_underrun), 32'(m_ur));

    if (e_we) fbpix[int'(wr_y) * 640 + int'(wr_x)] = wr_rgb;
    if (!rst_n) begin
      m_in_frame = 0; m_done = 0; m_ur = 0; m_rgb = 0; m_reads = 0; m_pix = 0;
    end else if (sc_frame_start) begin
      m_in_frame = 1; m_done = 0; m_ur = 0; m_rgb = 0; m_reads = 0; m_pix = 0;
    end else begin
      if (m_in_frame && m_reads == WORDS) m_done = 1;
      if (e_re) begin
        if (m_reads < 256) rd_cyc[m_reads] = m_cyc;
        m_reads++;
      end
      m_rgb = 0;
      if (sc_pix_en) begin
        j = m_pix / 8;
        avail = (j < m_reads) && (j < 256) && (rd_cyc[j] + 2 <= m_cyc);
        if (avail) begin
          m_rgb = fbpix[m_pix];
          m_pix++;
        end else begin
          m_ur = 1;
        end
      end
    end
    m_cyc++;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin : p_main
    int ready_lo, we_hi;
    logic [23:0] w;
    for (int p = 0; p < NPIX; p++) fbpix[p] = 3'((p + 3 * (p / 8)) % 8);
    for (int a = 0; a < WORDS; a++) begin
      w = '0;
      for (int i = 0; i < 8; i++) w = w | (24'(fbpix[a * 8 + i]) << (3 * i));
      ram[a] <= w;
    end

    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_rgb", 32'(sc_rgb), 32'd0);
    chk("rst_underrun", 32'(sc_underrun), 32'd0);
    chk("rst_mem_re", 32'(mem_re), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_wr_ready", 32'(wr_ready), 32'd1);
    chk("pattern_w0", 32'(ram[0]), 32'hFAC688);

    // write in IDLE
    tick; wr_valid = 1; wr_x = 10'd9; wr_y = 9'd1; wr_rgb = 3'd5;
    @(negedge clk);
    chk("idle_we", 32'(mem_we), 32'd1);
    chk("idle_addr", 32'(mem_addr), 32'd81);
    chk("idle_wdata", 32'(mem_wdata), 32'h28);
    chk("idle_wmask", 32'(mem_wmask), 32'h38);
    tick; wr_x = 10'd640; wr_y = 9'd0;
    @(negedge clk);
    chk("oor_x_ready", 32'(wr_ready), 32'd1);
    chk("oor_x_we", 32'(mem_we), 32'd0);
    tick; wr_x = 10'd5; wr_y = 9'd480;
    @(negedge clk);
    chk("oor_y_we", 32'(mem_we), 32'd0);
    tick; wr_valid = 0;

    // scanout
    tick; sc_frame_start = 1;
    tick; sc_frame_start = 0;
    @(negedge clk);
    chk("rd0_re", 32'(mem_re), 32'd1);
    chk("rd0_addr", 32'(mem_addr), 32'd0);
    tick;
    @(negedge clk);
    chk("rd1_re", 32'(mem_re), 32'd1);
    chk("rd1_addr", 32'(mem_addr), 32'd1);
    tick;
    @(negedge clk);
    chk("rd_gap", 32'(mem_re), 32'd0);
    for (int p = 0; p <= 700; p++) begin
      tick;
      sc_pix_en = (p < 700);
      @(negedge clk);
      if (p >= 1 && p <= 8) chk("scan_lit", 32'(sc_rgb), 32'(p - 1));
      if (p == 650) chk("scan_px649", 32'(sc_rgb), 32'd5);
    end

    // contention with writer held valid
    ready_lo = 0; we_hi = 0;
    wr_valid = 1; wr_y = 9'd400;
    for (int c = 0; c < 25; c++) begin
      tick;
      sc_frame_start = (c == 0);
      sc_pix_en = (c >= 4 && c < 20);
      wr_x = 10'((c * 37) % 640);
      wr_rgb = 3'(c % 8);
      @(negedge clk);
      if (!wr_ready) ready_lo++;
      if (mem_we) we_hi++;
    end
`ifndef FB_ARB_VBLANK_WRITE_EN
    chk("cont_ready_lo", 32'(ready_lo), 32'd4);
    chk("cont_we_hi", 32'(we_hi), 32'd21);
`endif
    tick; wr_valid = 0; sc_pix_en = 0;

    // underrun right after frame start
    tick; sc_frame_start = 1;
    tick; sc_frame_start = 0; sc_pix_en = 1;
    tick; sc_pix_en = 0;
    @(negedge clk);
    chk("ur_rgb", 32'(sc_rgb), 32'd0);
    chk("ur_flag", 32'(sc_underrun), 32'd1);
    tick; sc_pix_en = 1;
    tick;
    tick; sc_pix_en = 0;
    @(negedge clk);
    chk("ur_resume", 32'(sc_rgb), 32'd1);
    chk("ur_sticky", 32'(sc_underrun), 32'd1);
    tick; sc_frame_start = 1;
    tick; sc_frame_start = 0;
    @(negedge clk);
    chk("ur_clear", 32'(sc_underrun), 32'd0);

    // reset mid-frame while a read is returning
    repeat (3) tick;
    sc_pix_en = 1;
    repeat (17) tick;
    rst_n = 0;
    tick; rst_n = 1; sc_pix_en = 0;
    @(negedge clk);
    chk("midrst_rgb", 32'(sc_rgb), 32'd0);
    chk("midrst_re", 32'(mem_re), 32'd0);
    chk("midrst_ready", 32'(wr_ready), 32'd1);
    tick; sc_frame_start = 1;
    tick; sc_frame_start = 0;
    repeat (3) tick;
    sc_pix_en = 1;
    repeat (16) tick;
    sc_pix_en = 0;
    repeat (4) tick;
    @(negedge clk);
    chk("midrst_no_ur", 32'(sc_underrun), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
